// File: rtl/demux1to16_seq.sv
// rtl/demux1to16_seq.sv - sequential 1-to-16 demultiplexer rebuilding a 16-bit frame from a serial lane; optional DEMUX_ADDR_MODE_EN adds S16/Load addressed capture
module demux1to16_seq #(
   parameter logic [0:15] RESET_VAL = 16'h0000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        f,
   input  logic        En,
   input  logic        Sync,
`ifdef DEMUX_ADDR_MODE_EN
   input  logic [3:0]  S16,
   input  logic        Load,
`endif
   output logic [0:15] W,
   output logic [3:0]  Sel,
   output logic        Done
);

   logic [3:0]  sel_q,  sel_d;
   logic [0:15] stg_q,  stg_d;
   logic [0:15] w_q,    w_d;
   logic        done_q, done_d;
   logic [3:0]  wr_idx;

   // Pick the capture index: counter normally, S16 when addressed capture is requested
   always_comb begin
      wr_idx = sel_q;
`ifdef DEMUX_ADDR_MODE_EN
      if (Load) begin
         wr_idx = S16;
      end
`endif
   end

   // Next-state: Sync realigns the frame, En captures one bit and publishes on index 15
   always_comb begin
      sel_d  = sel_q;
      stg_d  = stg_q;
      w_d    = w_q;
      done_d = 1'b0;
      if (Sync) begin
         stg_d = RESET_VAL;
         sel_d = 4'd0;
         if (En) begin
            stg_d[0] = f;
            sel_d    = 4'd1;
         end
      end else if (En) begin
         stg_d[wr_idx] = f;
         sel_d         = wr_idx + 4'd1;
         if (wr_idx == 4'd15) begin
            // The new bit goes straight into W[15]; the staged copy is not yet visible
            w_d    = {stg_q[0:14], f};
            done_d = 1'b1;
         end
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge Clock) begin
      if (Reset) begin
         sel_q  <= 4'd0;
         stg_q  <= RESET_VAL;
         w_q    <= RESET_VAL;
         done_q <= 1'b0;
      end else begin
         sel_q  <= sel_d;
         stg_q  <= stg_d;
         w_q    <= w_d;
         done_q <= done_d;
      end
   end

   assign W    = w_q;
   assign Sel  = sel_q;
   assign Done = done_q;

endmodule
